// File: rtl/vigna_bus_arbiter.sv
// vigna_bus_arbiter: merges the vigna core's instruction (i_*) and data (d_*) masters onto
// one registered valid/ready memory port (m_*). One transaction is in flight at a time. The
// response is routed back only to the granted master.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   i_valid/i_addr/i_wdata/i_wstrb  instruction master request
//   i_ready/i_rdata                 instruction completion pulse and read data
//   d_valid/d_addr/d_wdata/d_wstrb  data master request (d_wstrb == 0 means read)
//   d_ready/d_rdata                 data completion pulse and read data
//   m_valid/m_addr/m_wdata/m_wstrb  registered memory request
//   m_ready/m_rdata                 memory completion (one cycle), read data valid with it
//
// Build option: define VIGNA_ARB_ROUND_ROBIN_EN to break simultaneous requests in favour of
// the master that was not granted last. Without it, data always beats instruction.
module vigna_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    d_valid,
  output logic                    d_ready,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb
);

`ifdef VIGNA_ARB_ROUND_ROBIN_EN
  localparam bit RoundRobin = 1'b1;
`else
  localparam bit RoundRobin = 1'b0;
`endif

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntI = 2'd1,
    StGntD = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    last_grant_q;  // 1: data master was granted last
  logic                    m_valid_q;
  logic [ADDR_WIDTH-1:0]   m_addr_q;
  logic [DATA_WIDTH-1:0]   m_wdata_q;
  logic [DATA_WIDTH/8-1:0] m_wstrb_q;
  logic                    pick_d;

  // Data wins unless round-robin is enabled, both request, and data was served last.
  always_comb begin
    pick_d = d_valid && !(RoundRobin && i_valid && last_grant_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      m_valid_q    <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_wstrb_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_d) begin
            m_valid_q <= 1'b1;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
            m_wstrb_q <= d_wstrb;
            state_q   <= StGntD;
          end else if (i_valid) begin
            m_valid_q <= 1'b1;
            m_addr_q  <= i_addr;
            m_wdata_q <= i_wdata;
            m_wstrb_q <= i_wstrb;
            state_q   <= StGntI;
          end
        end
        StGntI, StGntD: begin
          // m_addr is left as is; only the write-related fields are cleared.
          if (m_ready) begin
            m_valid_q    <= 1'b0;
            m_wdata_q    <= '0;
            m_wstrb_q    <= '0;
            last_grant_q <= (state_q == StGntD);
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Completion pulses are combinational from m_ready and suppressed while reset is high.
  assign i_ready = !reset && (state_q == StGntI) && m_ready;
  assign d_ready = !reset && (state_q == StGntD) && m_ready;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  assign m_valid = m_valid_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Testbench for vigna_bus_arbiter: directed scenarios plus a randomized phase. A transaction
// level reference model pushes every expected memory request into a scoreboard queue; the
// monitor pops it when the DUT raises m_valid and checks ready routing every cycle.
module tb_vigna_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

`ifdef VIGNA_ARB_ROUND_ROBIN_EN
  localparam bit RrMode = 1'b1;
`else
  localparam bit RrMode = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_valid = 1'b0, d_valid = 1'b0;
  logic          i_ready, d_ready;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] i_rdata, d_rdata;
  logic [DW-1:0] i_wdata = '0, d_wdata = '0;
  logic [SW-1:0] i_wstrb = '0, d_wstrb = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;

  vigna_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_rdata(d_rdata),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_rdata(m_rdata),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_d;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } txn_t;

  typedef struct {
    bit            is_d;
    logic [AW-1:0] addr;
    int            cyc;
  } glog_t;

  txn_t  exp_q[$];
  glog_t glog[$];
  txn_t  cur;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ip = 0, dp = 0, mv_hi = 0;

  // Reference model: at most one outstanding request; a free port takes the next request.
  bit model_busy = 1'b0, model_owner_d = 1'b0, model_last_d = 1'b1;
  bit mv_prev = 1'b0;

  // Memory model knobs
  int mem_wait = -1;
  int fix_wait = -1;
  int spur_mod = 0;
  bit fix_rdata_en = 1'b0;
  logic [DW-1:0] fix_rdata = '0;

  bit rand_en = 1'b0, rand_master_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model + monitor, sampled on the falling edge.
  initial begin
    bit ei, ed, pick;
    forever begin
      @(negedge clk);
      check("m_valid", m_valid, model_busy);
      if (m_valid && !mv_prev) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_unexpected: actual=m_valid required=no_request (t=%0t)", $time);
        end else begin
          cur = exp_q.pop_front();
          glog.push_back('{cur.is_d, cur.addr, cyc});
        end
      end
      if (m_valid) begin
        mv_hi++;
        check("m_addr", m_addr, cur.addr);
        check("m_wdata", m_wdata, cur.wdata);
        check("m_wstrb", m_wstrb, cur.wstrb);
      end else begin
        check("idle_wdata", m_wdata, 0);
        check("idle_wstrb", m_wstrb, 0);
      end
      ei = !reset && model_busy && !model_owner_d && m_ready;
      ed = !reset && model_busy && model_owner_d && m_ready;
      check("i_ready", i_ready, ei);
      check("d_ready", d_ready, ed);
      if (ei) check("i_rdata", i_rdata, m_rdata);
      if (ed) check("d_rdata", d_rdata, m_rdata);
      if (i_ready) ip++;
      if (d_ready) dp++;
      mv_prev = m_valid;
      if (reset) begin
        model_busy = 1'b0;
        model_last_d = 1'b1;
      end else if (model_busy) begin
        if (m_ready) begin
          model_busy = 1'b0;
          model_last_d = model_owner_d;
        end
      end else if (i_valid || d_valid) begin
        if (i_valid && d_valid) pick = RrMode ? !model_last_d : 1'b1;
        else pick = d_valid;
        if (pick) exp_q.push_back('{1'b1, d_addr, d_wdata, d_wstrb});
        else exp_q.push_back('{1'b0, i_addr, i_wdata, i_wstrb});
        model_busy = 1'b1;
        model_owner_d = pick;
      end
    end
  end

  // Memory responder: random or fixed wait, optional spurious m_ready while idle.
  initial begin
    forever begin
      @(posedge clk); #1;
      m_ready = 1'b0;
      if (!m_valid) begin
        mem_wait = -1;
        if (spur_mod > 0 && $urandom_range(0, spur_mod - 1) == 0) begin
          m_ready = 1'b1;
          m_rdata = $urandom;
        end
      end else begin
        if (mem_wait < 0) mem_wait = (fix_wait >= 0) ? fix_wait : $urandom_range(0, 3);
        if (mem_wait == 0) begin
          m_ready = 1'b1;
          m_rdata = fix_rdata_en ? fix_rdata : $urandom;
          mem_wait = -1;
        end else begin
          mem_wait--;
        end
      end
    end
  end

  // Random masters: hold the request until ready, then drop valid on the next edge.
  initial begin
    bit got;
    forever begin
      @(negedge clk); got = i_ready;
      @(posedge clk); #1;
      if (rand_master_en) begin
        if (i_valid && got) i_valid = 1'b0;
        else if (!i_valid && rand_en && $urandom_range(0, 2) == 0) begin
          i_valid = 1'b1;
          i_addr  = $urandom;
          i_wdata = ($urandom_range(0, 7) == 0) ? $urandom : '0;
          i_wstrb = ($urandom_range(0, 7) == 0) ? SW'($urandom) : '0;
        end
      end
    end
  end

  initial begin
    bit got;
    forever begin
      @(negedge clk); got = d_ready;
      @(posedge clk); #1;
      if (rand_master_en) begin
        if (d_valid && got) d_valid = 1'b0;
        else if (!d_valid && rand_en && $urandom_range(0, 2) == 0) begin
          d_valid = 1'b1;
          d_addr  = $urandom;
          d_wdata = $urandom;
          d_wstrb = SW'($urandom);
        end
      end
    end
  end

  // Directed request; called at posedge+1, returns at posedge+1. keep leaves valid high so
  // the caller can present the next request immediately.
  task automatic req(input bit is_d, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input logic [SW-1:0] wstrb, input bit keep, output logic [DW-1:0] rdata);
    bit ok = 1'b0;
    if (is_d) begin
      d_valid = 1'b1; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb;
    end else begin
      i_valid = 1'b1; i_addr = addr; i_wdata = wdata; i_wstrb = wstrb;
    end
    rdata = '0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = is_d ? d_ready : i_ready;
      rdata = is_d ? d_rdata : i_rdata;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL req_timeout: actual=no_ready required=ready addr=%0h", addr);
    end
    @(posedge clk); #1;
    if (!keep) begin
      if (is_d) d_valid = 1'b0;
      else i_valid = 1'b0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [DW-1:0] rd, rd2;
    int ip0, dp0, mv0;
    bit done;

    // Reset state
    step(3);
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_m_wstrb", m_wstrb, 0);
    check("rst_i_ready", i_ready, 0);
    check("rst_d_ready", d_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(1);

    // Simultaneous requests right after reset (last grant = data)
    fix_wait = 0;
    glog.delete();
    fork
      req(1'b0, 32'h200, '0, '0, 1'b0, rd);
      req(1'b1, 32'h300, 32'h5555_aaaa, 4'h3, 1'b0, rd2);
    join
    check("both_count", glog.size(), 2);
    check("both_first", glog[0].is_d, RrMode ? 1'b0 : 1'b1);
    check("both_second", glog[1].is_d, RrMode ? 1'b1 : 1'b0);
    check("both_gap", glog[1].cyc - glog[0].cyc, 2);
    step(2);

    // Instruction read, zero-wait
    fix_rdata_en = 1'b1; fix_rdata = 32'h13;
    glog.delete(); ip0 = ip; dp0 = dp;
    req(1'b0, 32'h10, '0, '0, 1'b0, rd);
    check("t1_rdata", rd, 32'h13);
    check("t1_addr", glog[0].addr, 32'h10);
    check("t1_ipulse", ip - ip0, 1);
    check("t1_dpulse", dp - dp0, 0);
    step(2);

    // Data write with 3 wait cycles
    fix_wait = 3;
    ip0 = ip; dp0 = dp; mv0 = mv_hi;
    req(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 1'b0, rd);
    step(1);
    check("t2_dpulse", dp - dp0, 1);
    check("t2_mvcycles", mv_hi - mv0, 4);
    check("t2_wstrb_after", m_wstrb, 0);
    step(1);

    // Spurious m_ready while idle
    spur_mod = 1; ip0 = ip; dp0 = dp;
    step(8);
    spur_mod = 0;
    step(1);
    check("t4_ipulse", ip - ip0, 0);
    check("t4_dpulse", dp - dp0, 0);
    check("t4_m_valid", m_valid, 0);

    // Reset while a transaction is pending
    fix_wait = 5; glog.delete(); ip0 = ip; done = 1'b0;
    fork
      begin
        req(1'b0, 32'h40, '0, '0, 1'b0, rd);
        done = 1'b1;
      end
    join_none
    for (int n = 0; n < 20 && !m_valid; n++) @(negedge clk);
    check("t5_started", m_valid, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t5_dropped", m_valid, 0);
    for (int n = 0; n < 60 && !done; n++) step(1);
    check("t5_done", done, 1);
    check("t5_ipulse", ip - ip0, 1);
    check("t5_grants", glog.size(), 2);
    step(2);

    // Back-to-back data reads, zero-wait
    fix_wait = 0; glog.delete();
    req(1'b1, 32'h4, '0, '0, 1'b1, rd);
    req(1'b1, 32'h8, '0, '0, 1'b0, rd);
    check("t6_count", glog.size(), 2);
    check("t6_addr0", glog[0].addr, 32'h4);
    check("t6_addr1", glog[1].addr, 32'h8);
    check("t6_gap", glog[1].cyc - glog[0].cyc, 2);
    step(2);

    // Randomized traffic
    fix_wait = -1; fix_rdata_en = 1'b0; spur_mod = 4;
    rand_master_en = 1'b1; rand_en = 1'b1;
    step(1500);
    rand_en = 1'b0;
    for (int n = 0; n < 200 && (i_valid || d_valid); n++) step(1);
    check("drain_idle", i_valid || d_valid, 0);
    spur_mod = 0;
    step(3);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vigna_bus_arbiter.md
Name: vigna_bus_arbiter

Overview:
- Downstream of the vigna core.
- Merges the core's instruction port (i_*) and data port (d_*) into one valid/ready memory port (m_*) for a single-ported RAM or bus.
- One transaction in flight at a time; the granted request is registered onto the memory port. The response is routed back to the granted master only.
- Fixed priority by default; round-robin when the optional macro is defined.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses; must be a multiple of 8; strobe width is DATA_WIDTH/8

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous reset, active-high
i_valid  input  1  instruction master request
i_ready  output  1  instruction master completion pulse
i_addr  input  ADDR_WIDTH  instruction address
i_rdata  output  DATA_WIDTH  instruction read data
i_wdata  input  DATA_WIDTH  instruction write data (normally 0)
i_wstrb  input  DATA_WIDTH/8  instruction write strobe (normally 0)
d_valid  input  1  data master request
d_ready  output  1  data master completion pulse
d_addr  input  ADDR_WIDTH  data address
d_rdata  output  DATA_WIDTH  data read data
d_wdata  input  DATA_WIDTH  data write data
d_wstrb  input  DATA_WIDTH/8  data write strobe; 0 means read
m_valid  output  1  memory request, registered
m_ready  input  1  memory completion, one cycle, rdata valid with it
m_addr  output  ADDR_WIDTH  memory address, registered
m_rdata  input  DATA_WIDTH  memory read data
m_wdata  output  DATA_WIDTH  memory write data, registered
m_wstrb  output  DATA_WIDTH/8  memory write strobe, registered

Behaviour:
- Reset is synchronous and active-high; one clock domain (clk).
- Reset values: m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0, state=IDLE, last_grant=D. i_ready and d_ready read 0 while reset is high.
- Master protocol: a master holds valid, addr, wdata and wstrb stable until it sees ready=1 for one cycle. It then drops valid on the next edge.
- States: IDLE, GNT_I, GNT_D.
- IDLE, no valid asserted: stay.
- IDLE, d_valid=1: latch d_addr/d_wdata/d_wstrb into m_*, set m_valid=1, go GNT_D.
- IDLE, only i_valid=1: same with the i_* fields, go GNT_I.
- IDLE, both valid: d wins (fixed priority).
- GNT_x, m_ready=0: hold all m_* outputs.
- GNT_x, m_ready=1: x_ready=1 combinationally in that same cycle. The other master's ready stays 0. At the edge: m_valid<=0, m_wstrb<=0, m_wdata<=0, last_grant<=x, state<=IDLE.
- i_ready = (state==GNT_I) && m_ready; d_ready = (state==GNT_D) && m_ready.
- i_rdata and d_rdata both carry m_rdata combinationally. Data is meaningful only with the matching ready.
- Latency: request seen at edge N gives m_valid high in cycle N+1. With zero-wait memory (m_ready in cycle N+1), the master sees ready in cycle N+1.
- Minimum 2 cycles per transaction; one IDLE cycle between back-to-back grants.
- m_ready while in IDLE: ignored, no ready pulse generated.
- Master drops valid while granted (protocol violation): transaction still completes and the ready pulse is still issued. No abort.
- Valid from the non-granted master while busy: not sampled. It is serviced from IDLE after the current transaction.
- Reset mid-transaction: m_valid drops at that edge. The pending ready is never issued; state goes to IDLE.
- No combinational path from i_valid/d_valid/addr to any m_* output.

Optional Feature:
- Macro: VIGNA_ARB_ROUND_ROBIN_EN.
- Defined: when both valids are high in IDLE, grant the master that is not last_grant. Single requests are granted as usual.
- Undefined: fixed priority, data over instruction. last_grant is still maintained but does not affect grant.

Test Plan:
- i_valid=1, i_addr=0x0000_0010, memory returns m_ready in the next cycle with m_rdata=0x0000_0013 -> m_valid high one cycle with m_addr=0x10 and m_wstrb=0; i_ready=1 and i_rdata=0x13 in the same cycle; d_ready stays 0.
- d_valid=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=0xF, memory waits 3 cycles before m_ready -> m_* held stable for all 4 cycles; d_ready pulses exactly once; m_wstrb returns to 0 after.
- i_valid and d_valid rise in the same cycle, macro undefined -> d granted first, then i after one IDLE cycle. Repeat with the macro defined and last_grant=D -> i granted first.
- m_ready pulsed while IDLE with no requests -> no ready to either master; state stays IDLE.
- reset asserted in the cycle after m_valid rises -> m_valid=0 in the next cycle; i_ready and d_ready never pulse; the next request after reset is serviced normally.
- Back-to-back d reads at addresses 0x4 then 0x8, zero-wait memory -> each transaction takes 2 cycles with one IDLE gap; addresses are presented in order.
